// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Controller tag for a master index; tag 0 is reserved for "idle".
  function automatic int unsigned tag_of(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner picker: urgent masters first (lowest index), otherwise
// a priority encode over the request vector rotated to start after rr_ptr.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     urgent_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  input  arb_mode_t        mode_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int           start;
  int           hit;
  logic         found;
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;

  // Rotate so the search origin sits at bit 0, encode, then unrotate the hit.
  always_comb begin
    start = (mode_i == ARB_RR) ? ((int'(rr_ptr_i) + 1) % N) : 0;
    dbl   = {req_i, req_i};
    rot   = N'(dbl >> start);
    found = 1'b0;
    hit   = 0;
    if (|urgent_i) begin
      for (int i = 0; i < N; i++) begin
        if (!found && urgent_i[i]) begin
          found = 1'b1;
          hit   = i;
        end
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!found && rot[j]) begin
          found = 1'b1;
          hit   = (start + j) % N;
        end
      end
    end
    valid_o = found;
    idx_o   = IDX_W'(hit);
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-master arbiter in front of the single-port SDRAM controller: grant FSM,
// registered command fields, starvation aging and tag-routed read return.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 5,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 1,
  parameter int MAX_WAIT    = 64,
  localparam int TAG_W      = $clog2(NUM_MASTERS + 1),
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_request,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_burst,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byte_enable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_rdvalid,
  output logic [NUM_MASTERS-1:0]        m_complete,
  output logic [TAG_W-1:0]              sdram_req,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic                          sdram_write,
  output logic                          sdram_burst,
  output logic [BE_W-1:0]               sdram_byte_enable,
  output logic [DATA_W-1:0]             sdram_wdata,
  input  logic                          sdram_ack,
  input  logic [DATA_W-1:0]             sdram_rdata,
  input  logic [TAG_W-1:0]              sdram_rdvalid,
  input  logic                          sdram_complete
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam arb_mode_t MODE = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

  // Per-master views of the packed command buses.
  logic [NUM_MASTERS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_MASTERS-1:0][BE_W-1:0]   be_a;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] wd_a;
  assign addr_a = m_addr;
  assign be_a   = m_byte_enable;
  assign wd_a   = m_wdata;

  arb_state_t                         state_q, state_d;
  logic [IDX_W-1:0]                   grant_q, grant_d;
  logic [IDX_W-1:0]                   rr_q, rr_d;
  logic [NUM_MASTERS-1:0][CNT_W-1:0]  wait_q, wait_d;
  logic [TAG_W-1:0]                   req_q, req_d;
  logic [ADDR_W-1:0]                  addr_q, addr_d;
  logic                               wr_q, wr_d;
  logic                               burst_q, burst_d;
  logic [BE_W-1:0]                    be_q, be_d;
  logic [DATA_W-1:0]                  wd_q, wd_d;

  logic [NUM_MASTERS-1:0]             urgent;
  logic                               pick_valid;
  logic [IDX_W-1:0]                   pick_idx;

  // A master is urgent once its wait counter has saturated at the threshold.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      urgent[i] = (MAX_WAIT > 0) && m_request[i] && (wait_q[i] == CNT_W'(MAX_WAIT));
  end

  sdram_arb_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (m_request),
    .urgent_i (urgent),
    .rr_ptr_i (rr_q),
    .mode_i   (MODE),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // Grant FSM: latch the winner's command in IDLE, hold it in GRANT until ack.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    burst_d = burst_q;
    be_d    = be_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = pick_idx;
          req_d   = TAG_W'(tag_of(int'(pick_idx)));
          addr_d  = addr_a[pick_idx];
          wr_d    = m_write[pick_idx];
          burst_d = m_burst[pick_idx];
          be_d    = be_a[pick_idx];
          wd_d    = wd_a[pick_idx];
        end else begin
          req_d   = '0;
        end
      end
      GRANT: begin
        if (sdram_ack) begin
          state_d = IDLE;
          req_d   = '0;
          if (MODE == ARB_RR) rr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Aging: count cycles spent requesting without holding the grant.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!m_request[i]) begin
        wait_d[i] = '0;
      end else if (state_q == GRANT && grant_q == IDX_W'(i)) begin
        if (sdram_ack) wait_d[i] = '0;
      end else if (MAX_WAIT > 0 && wait_q[i] != CNT_W'(MAX_WAIT)) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  // State and command registers; reset drops any pending command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_MASTERS - 1);
      wait_q  <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      burst_q <= burst_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
    end
  end

  // Ack and tag-decoded return path; the return side ignores FSM state.
  always_comb begin
    m_ack      = '0;
    m_rdvalid  = '0;
    m_complete = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ack[i]      = sdram_ack && (state_q == GRANT) && (grant_q == IDX_W'(i));
      m_rdvalid[i]  = (sdram_rdvalid == TAG_W'(tag_of(i)));
      m_complete[i] = sdram_complete && (sdram_rdvalid == TAG_W'(tag_of(i)));
    end
  end

  assign m_rdata           = sdram_rdata;
  assign sdram_req         = req_q;
  assign sdram_addr        = addr_q;
  assign sdram_write       = wr_q;
  assign sdram_burst       = burst_q;
  assign sdram_byte_enable = be_q;
  assign sdram_wdata       = wd_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: fixed priority, aging, return routing, round-robin,
// mid-grant reset and the 1/15-master parameter corners.
module tb_sdram_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // u_fix: 5 masters, fixed priority, MAX_WAIT 8
  logic [4:0] f_req, f_wr, f_bu, f_ack, f_rdv, f_cmp;
  logic [129:0] f_addr; logic [19:0] f_be; logic [159:0] f_wd;
  logic [31:0] f_rdata, f_swd, f_srdata; logic [2:0] f_sreq, f_srdv;
  logic [25:0] f_saddr; logic f_swr, f_sbu, f_sack, f_scmp; logic [3:0] f_sbe;
  // u_rr: 5 masters, round-robin, MAX_WAIT 64
  logic [4:0] r_req, r_wr, r_bu, r_ack, r_rdv, r_cmp;
  logic [129:0] r_addr; logic [19:0] r_be; logic [159:0] r_wd;
  logic [31:0] r_rdata, r_swd, r_srdata; logic [2:0] r_sreq, r_srdv;
  logic [25:0] r_saddr; logic r_swr, r_sbu, r_sack, r_scmp; logic [3:0] r_sbe;
  // u_n1: single master
  logic a_req, a_wr, a_bu, a_ack, a_rdv, a_cmp;
  logic [25:0] a_addr, a_saddr; logic [3:0] a_be, a_sbe; logic [31:0] a_wd, a_rdata, a_swd, a_srdata;
  logic a_sreq, a_srdv, a_swr, a_sbu, a_sack, a_scmp;
  // u_n15: 15 masters, fixed, aging off
  logic [14:0] b_req, b_wr, b_bu, b_ack, b_rdv, b_cmp;
  logic [389:0] b_addr; logic [59:0] b_be; logic [479:0] b_wd;
  logic [31:0] b_rdata, b_swd, b_srdata; logic [3:0] b_sreq, b_srdv;
  logic [25:0] b_saddr; logic b_swr, b_sbu, b_sack, b_scmp; logic [3:0] b_sbe;

  sdram_port_arbiter #(.NUM_MASTERS(5), .ARB_MODE(0), .MAX_WAIT(8)) u_fix (
    .clock(clock), .reset(reset), .m_request(f_req), .m_addr(f_addr), .m_write(f_wr),
    .m_burst(f_bu), .m_byte_enable(f_be), .m_wdata(f_wd), .m_ack(f_ack), .m_rdata(f_rdata),
    .m_rdvalid(f_rdv), .m_complete(f_cmp), .sdram_req(f_sreq), .sdram_addr(f_saddr),
    .sdram_write(f_swr), .sdram_burst(f_sbu), .sdram_byte_enable(f_sbe), .sdram_wdata(f_swd),
    .sdram_ack(f_sack), .sdram_rdata(f_srdata), .sdram_rdvalid(f_srdv), .sdram_complete(f_scmp));

  sdram_port_arbiter #(.NUM_MASTERS(5), .ARB_MODE(1), .MAX_WAIT(64)) u_rr (
    .clock(clock), .reset(reset), .m_request(r_req), .m_addr(r_addr), .m_write(r_wr),
    .m_burst(r_bu), .m_byte_enable(r_be), .m_wdata(r_wd), .m_ack(r_ack), .m_rdata(r_rdata),
    .m_rdvalid(r_rdv), .m_complete(r_cmp), .sdram_req(r_sreq), .sdram_addr(r_saddr),
    .sdram_write(r_swr), .sdram_burst(r_sbu), .sdram_byte_enable(r_sbe), .sdram_wdata(r_swd),
    .sdram_ack(r_sack), .sdram_rdata(r_srdata), .sdram_rdvalid(r_srdv), .sdram_complete(r_scmp));

  sdram_port_arbiter #(.NUM_MASTERS(1), .ARB_MODE(1), .MAX_WAIT(64)) u_n1 (
    .clock(clock), .reset(reset), .m_request(a_req), .m_addr(a_addr), .m_write(a_wr),
    .m_burst(a_bu), .m_byte_enable(a_be), .m_wdata(a_wd), .m_ack(a_ack), .m_rdata(a_rdata),
    .m_rdvalid(a_rdv), .m_complete(a_cmp), .sdram_req(a_sreq), .sdram_addr(a_saddr),
    .sdram_write(a_swr), .sdram_burst(a_sbu), .sdram_byte_enable(a_sbe), .sdram_wdata(a_swd),
    .sdram_ack(a_sack), .sdram_rdata(a_srdata), .sdram_rdvalid(a_srdv), .sdram_complete(a_scmp));

  sdram_port_arbiter #(.NUM_MASTERS(15), .ARB_MODE(0), .MAX_WAIT(0)) u_n15 (
    .clock(clock), .reset(reset), .m_request(b_req), .m_addr(b_addr), .m_write(b_wr),
    .m_burst(b_bu), .m_byte_enable(b_be), .m_wdata(b_wd), .m_ack(b_ack), .m_rdata(b_rdata),
    .m_rdvalid(b_rdv), .m_complete(b_cmp), .sdram_req(b_sreq), .sdram_addr(b_saddr),
    .sdram_write(b_swr), .sdram_burst(b_sbu), .sdram_byte_enable(b_sbe), .sdram_wdata(b_swd),
    .sdram_ack(b_sack), .sdram_rdata(b_srdata), .sdram_rdvalid(b_srdv), .sdram_complete(b_scmp));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int ag_exp[6] = '{1, 1, 1, 1, 4, 1};
  int rr_exp[6] = '{1, 2, 3, 4, 5, 1};
  logic [4:0] e5, acc;

  initial begin
    reset = 1'b1;
    {f_req, f_sack, f_srdv, f_scmp, f_srdata} = '0;
    {r_req, r_sack, r_srdv, r_scmp, r_srdata} = '0;
    {a_req, a_sack, a_srdv, a_scmp, a_srdata} = '0;
    {b_req, b_sack, b_srdv, b_scmp, b_srdata} = '0;
    // Master i: addr 0x100+i, wdata 0xA0000000+i, be i+1, write on odd i, burst on even i.
    for (int i = 0; i < 15; i++) begin
      b_addr[i*26 +: 26] = 26'(32'h100 + i);
      b_wd[i*32 +: 32]   = 32'hA000_0000 + 32'(i);
      b_be[i*4 +: 4]     = 4'(i + 1);
      b_wr[i] = i[0];
      b_bu[i] = ~i[0];
    end
    f_addr = b_addr[129:0]; f_wd = b_wd[159:0]; f_be = b_be[19:0]; f_wr = b_wr[4:0]; f_bu = b_bu[4:0];
    r_addr = f_addr; r_wd = f_wd; r_be = f_be; r_wr = f_wr; r_bu = f_bu;
    a_addr = b_addr[25:0]; a_wd = b_wd[31:0]; a_be = b_be[3:0]; a_wr = b_wr[0]; a_bu = b_bu[0];

    #2;
    chk("rst_req", f_sreq, 0);
    chk("rst_addr", f_saddr, 0);
    chk("rst_wr_bu", {f_swr, f_sbu}, 0);
    chk("rst_be", f_sbe, 0);
    chk("rst_wdata", f_swd, 0);
    chk("rst_ack_rdv_cmp", {f_ack, f_rdv, f_cmp}, 0);
    chk("rst_rr_req", r_sreq, 0);
    tick(); tick();
    reset = 1'b0;

    // Fixed priority: masters 2 and 4.
    f_req = 5'b10100;
    tick();
    chk("fx_tag1", f_sreq, 3);
    chk("fx_addr1", f_saddr, 26'h102);
    chk("fx_wr_bu1", {f_swr, f_sbu}, 2'b01);
    chk("fx_be1", f_sbe, 4'h3);
    chk("fx_wd1", f_swd, 32'hA000_0002);
    chk("fx_noack", f_ack, 0);
    tick();
    chk("fx_hold", f_sreq, 3);
    f_sack = 1'b1; #1;
    chk("fx_ack1", f_ack, 5'b00100);
    tick();
    f_sack = 1'b0; f_req[2] = 1'b0;
    chk("fx_idle", f_sreq, 0);
    f_sack = 1'b1; #1;
    chk("fx_idle_ack_ignored", f_ack, 0);
    f_sack = 1'b0;
    tick();
    chk("fx_tag2", f_sreq, 5);
    chk("fx_addr2", f_saddr, 26'h104);
    chk("fx_be2", f_sbe, 4'h5);

    // Read return for master 1 while master 4 holds the grant.
    for (int b = 1; b <= 8; b++) begin
      f_srdv = 3'd2; f_scmp = (b == 8); f_srdata = 32'hD000_0000 + 32'(b);
      #1;
      chk("rt_rdv", f_rdv, 5'b00010);
      chk("rt_cmp", f_cmp, (b == 8) ? 5'b00010 : 5'b00000);
      chk("rt_data", f_rdata, 32'hD000_0000 + 32'(b));
      tick();
    end
    f_srdv = 3'd0; f_scmp = 1'b0; #1;
    chk("rt_off", {f_rdv, f_cmp}, 0);
    chk("rt_grant_held", f_sreq, 5);
    f_srdv = 3'd6; f_scmp = 1'b1; #1;
    chk("rt_tag6", {f_rdv, f_cmp}, 0);
    f_srdv = 3'd7; #1;
    chk("rt_tag7", {f_rdv, f_cmp}, 0);
    f_srdv = 3'd0; f_scmp = 1'b0;
    f_sack = 1'b1; #1;
    chk("fx_ack2", f_ack, 5'b10000);
    tick();
    f_sack = 1'b0; f_req = '0;
    chk("fx_done", f_sreq, 0);

    // Aging: master 0 always requesting, master 3 once.
    f_req = 5'b01001;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ag_tag", f_sreq, ag_exp[k]);
      e5 = '0; e5[ag_exp[k]-1] = 1'b1;
      f_sack = 1'b1; #1;
      chk("ag_ack", f_ack, e5);
      tick();
      f_sack = 1'b0;
      if (k == 4) f_req[3] = 1'b0;
      chk("ag_idle", f_sreq, 0);
    end
    f_req = '0;

    // Round-robin with all five requesting.
    r_req = 5'b11111; acc = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_tag", r_sreq, rr_exp[k]);
      e5 = '0; e5[rr_exp[k]-1] = 1'b1;
      r_sack = 1'b1; #1;
      chk("rr_ack", r_ack, e5);
      if (k < 5) acc = acc | r_ack;
      tick();
      r_sack = 1'b0;
      chk("rr_idle", r_sreq, 0);
    end
    chk("rr_each_once", acc, 5'b11111);

    // Reset while master 1 is granted.
    tick();
    chk("rs_tag", r_sreq, 2);
    reset = 1'b1; r_sack = 1'b1; #1;
    chk("rs_req", r_sreq, 0);
    chk("rs_addr", r_saddr, 0);
    chk("rs_wd", r_swd, 0);
    chk("rs_noack", r_ack, 0);
    tick();
    reset = 1'b0; r_sack = 1'b0;
    tick();
    chk("rs_first", r_sreq, 1);
    r_sack = 1'b1; #1;
    chk("rs_ack0", r_ack, 5'b00001);
    tick();
    r_sack = 1'b0; r_req = '0;

    // Single master.
    a_req = 1'b1;
    tick();
    chk("n1_tag", a_sreq, 1);
    chk("n1_addr", a_saddr, 26'h100);
    a_sack = 1'b1; #1;
    chk("n1_ack", a_ack, 1);
    tick();
    a_sack = 1'b0; a_req = 1'b0;
    chk("n1_idle", a_sreq, 0);
    a_srdv = 1'b1; a_scmp = 1'b1; #1;
    chk("n1_ret", {a_rdv, a_cmp}, 2'b11);
    a_srdv = 1'b0; #1;
    chk("n1_ret_off", {a_rdv, a_cmp}, 2'b00);
    a_scmp = 1'b0;

    // Fifteen masters: 7 and 14.
    b_req = 15'h4080;
    tick();
    chk("n15_tag1", b_sreq, 8);
    chk("n15_addr1", b_saddr, 26'h107);
    b_sack = 1'b1; #1;
    chk("n15_ack1", b_ack, 15'h0080);
    tick();
    b_sack = 1'b0; b_req = 15'h4000;
    chk("n15_idle", b_sreq, 0);
    tick();
    chk("n15_tag2", b_sreq, 15);
    chk("n15_wd2", b_swd, 32'hA000_000E);
    b_sack = 1'b1; #1;
    chk("n15_ack2", b_ack, 15'h4000);
    tick();
    b_sack = 1'b0; b_req = '0;
    b_srdv = 4'd15; b_scmp = 1'b1; #1;
    chk("n15_rdv", b_rdv, 15'h4000);
    chk("n15_cmp", b_cmp, 15'h4000);
    b_srdv = 4'd0; #1;
    chk("n15_rdv_off", {b_rdv, b_cmp}, 0);
    b_scmp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
